// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: reset, lock-qualification and dynamic-phase sequencer for
// the Gowin rPLL. Runs on the PLL reference clock and drives the rPLL's
// RESET, RESET_P, PSDA and DUTYDA inputs. The asynchronous LOCK output is
// synchronised, then lock must stay stable before the downstream reset is
// released.
// Optional feature: define PLL_LOSS_CNT_EN to build the saturating 8-bit
// lock-loss counter. Without it, lost_cnt is tied to zero.
module pll_lock_ctrl #(
  parameter int unsigned RST_CYCLES   = 64,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned GUARD_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       ps_req,
  input  logic [3:0] ps_phase,
  input  logic [3:0] ps_duty,
  output logic       ps_ack,
  output logic       pll_reset,
  output logic       pll_reset_p,
  output logic [3:0] pll_psda,
  output logic [3:0] pll_dutyda,
  output logic       rst_out_n,
  output logic       locked,
  output logic       fail,
  output logic [7:0] lost_cnt
);

  localparam int unsigned MAX_AB  = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int unsigned MAX_CD  = (LOCK_TIMEOUT > GUARD_CYCLES) ? LOCK_TIMEOUT : GUARD_CYCLES;
  localparam int unsigned MAX_P   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW      = ($clog2(MAX_P) < 1) ? 1 : $clog2(MAX_P);
  localparam int unsigned RW      = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);

  // The counter is reloaded with N-1 and runs down to zero, so N edges are
  // spent in each timed state and N itself never has to fit in CW bits.
  localparam logic [CW-1:0] RST_LD = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LD  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LD  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] GD_LD  = CW'(GUARD_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    S_RST, S_WAIT_LOCK, S_STABLE, S_RUN, S_PS_HOLD, S_PS_APPLY, S_PS_SETTLE, S_FAIL
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            sync1_q, sync2_q;
  logic            lock_s;
  logic            pll_reset_q, pll_reset_d;
  logic            rst_out_n_q, rst_out_n_d;
  logic            locked_q, locked_d;
  logic            fail_q, fail_d;
  logic            ps_ack_q, ps_ack_d;
  logic [3:0]      psda_q, psda_d;
  logic [3:0]      dutyda_q, dutyda_d;
`ifdef PLL_LOSS_CNT_EN
  logic [7:0]      lost_q, lost_d;
`endif

  assign lock_s = sync2_q;

  // Next-state, counter and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
    retry_d = retry_q;
`ifdef PLL_LOSS_CNT_EN
    lost_d  = lost_q;
`endif
    case (state_q)
      S_RST: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = TO_LD;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
          cnt_d   = ST_LD;
        end else if (cnt_q == '0) begin
          retry_d = retry_q + RW'(1);
          if (retry_q >= RETRY_LAST) begin
            state_d = S_FAIL;
          end else begin
            state_d = S_RST;
            cnt_d   = RST_LD;
          end
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = TO_LD;
        end else if (cnt_q == '0) begin
          state_d = S_RUN;
          retry_d = '0;
        end
      end
      S_RUN: begin
        // Lock loss wins over a simultaneous request; the request stays pending.
        if (!lock_s) begin
          state_d = S_RST;
          cnt_d   = RST_LD;
`ifdef PLL_LOSS_CNT_EN
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
`endif
        end else if (ps_req) begin
          state_d = S_PS_HOLD;
          cnt_d   = GD_LD;
        end
      end
      S_PS_HOLD: begin
        if (cnt_q == '0) state_d = S_PS_APPLY;
      end
      S_PS_APPLY: begin
        state_d = S_PS_SETTLE;
        cnt_d   = GD_LD;
      end
      S_PS_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_STABLE;
          cnt_d   = ST_LD;
        end
      end
      S_FAIL: state_d = S_FAIL;
      default: begin
        state_d = S_RST;
        cnt_d   = RST_LD;
      end
    endcase

    pll_reset_d = (state_d == S_RST);
    rst_out_n_d = (state_d == S_RUN);
    locked_d    = (state_d == S_RUN);
    fail_d      = (state_d == S_FAIL);
    ps_ack_d    = (state_q == S_PS_APPLY);
    psda_d      = (state_q == S_PS_APPLY) ? ps_phase : psda_q;
    dutyda_d    = (state_q == S_PS_APPLY) ? ps_duty  : dutyda_q;
  end

  // Synchroniser, FSM state and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= S_RST;
      cnt_q       <= RST_LD;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      rst_out_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      ps_ack_q    <= 1'b0;
      psda_q      <= 4'h0;
      dutyda_q    <= 4'h8;
`ifdef PLL_LOSS_CNT_EN
      lost_q      <= '0;
`endif
    end else begin
      sync1_q     <= pll_lock;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      rst_out_n_q <= rst_out_n_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      ps_ack_q    <= ps_ack_d;
      psda_q      <= psda_d;
      dutyda_q    <= dutyda_d;
`ifdef PLL_LOSS_CNT_EN
      lost_q      <= lost_d;
`endif
    end
  end

  assign pll_reset   = pll_reset_q;
  assign pll_reset_p = pll_reset_q;
  assign rst_out_n   = rst_out_n_q;
  assign locked      = locked_q;
  assign fail        = fail_q;
  assign ps_ack      = ps_ack_q;
  assign pll_psda    = psda_q;
  assign pll_dutyda  = dutyda_q;
`ifdef PLL_LOSS_CNT_EN
  assign lost_cnt    = lost_q;
`else
  assign lost_cnt    = 8'h00;
`endif

endmodule
